// File: rtl/rf_wb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rf_wb_pkg
// Brief   : Shared widths, load-buffer entry type and read-bypass helper for
//           the register-file writeback controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int REG_W     = 32;
    localparam int ADDR_W    = 5;
    localparam int DEPTH_DEF = 2;

    // One buffered load result; valid drops when a younger ALU write hits rd.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

    // Read-port bypass: r0 is hardwired zero, the write in flight wins over
    // buffered loads, and buffered loads win over the raw register file.
    function automatic logic [REG_W-1:0] bypass(
        input logic [ADDR_W-1:0] ra,
        input logic              wr,
        input logic [ADDR_W-1:0] rw,
        input logic [REG_W-1:0]  dw,
        input logic              buf_hit,
        input logic [REG_W-1:0]  buf_data,
        input logic [REG_W-1:0]  rf_data
    );
        if (ra == '0)
            return '0;
        else if (wr && (rw == ra))
            return dw;
        else if (buf_hit)
            return buf_data;
        else
            return rf_data;
    endfunction

endpackage : rf_wb_pkg
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rf_wb_fifo
// Brief   : Load-result buffer. Circular storage with per-entry invalidate by
//           destination register, head selection that skips invalidated
//           slots, two youngest-match lookup ports and a pending bitmap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
)(
    input  logic               clk,
    input  logic               rst,
    // enqueue
    input  logic               i_push,
    input  logic [ADDR_W-1:0]  i_push_rd,
    input  logic [REG_W-1:0]   i_push_data,
    output logic               o_full,
    // dequeue of the oldest still-valid entry
    input  logic               i_pop,
    output logic               o_head_vld,
    output logic [ADDR_W-1:0]  o_head_rd,
    output logic [REG_W-1:0]   o_head_data,
    // invalidate every entry targeting i_inv_rd
    input  logic               i_inv_en,
    input  logic [ADDR_W-1:0]  i_inv_rd,
    // youngest-match lookups
    input  logic [ADDR_W-1:0]  i_lka_rd,
    output logic               o_lka_hit,
    output logic [REG_W-1:0]   o_lka_data,
    input  logic [ADDR_W-1:0]  i_lkb_rd,
    output logic               o_lkb_hit,
    output logic [REG_W-1:0]   o_lkb_data,
    output logic [REG_W-1:0]   o_pending
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [IW-1:0]     r_rptr;
    logic [IW-1:0]     r_wptr;
    logic [CW-1:0]     r_count;

    logic [IW-1:0]     w_slot [DEPTH];
    logic [IW:0]       w_slot_sum;
    logic              w_found;
    logic [IW-1:0]     w_head_off;
    logic              w_pop;
    logic [CW-1:0]     w_adv;
    logic [SW-1:0]     w_rptr_sum;
    logic [IW-1:0]     w_rptr_nxt;
    logic [IW-1:0]     w_wptr_nxt;

    // Physical slot for each age offset, oldest first.
    always_comb begin
        w_slot_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_sum = {1'b0, r_rptr} + (IW+1)'(i);
            if (w_slot_sum >= (IW+1)'(DEPTH))
                w_slot_sum = w_slot_sum - (IW+1)'(DEPTH);
            w_slot[i] = w_slot_sum[IW-1:0];
        end
    end

    // Scan occupied slots oldest to youngest: head, lookups (last hit is youngest), pending.
    always_comb begin
        w_found     = 1'b0;
        w_head_off  = '0;
        o_head_rd   = '0;
        o_head_data = '0;
        o_lka_hit   = 1'b0;
        o_lka_data  = '0;
        o_lkb_hit   = 1'b0;
        o_lkb_data  = '0;
        o_pending   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(r_count)) && r_mem[w_slot[i]].valid) begin
                if (!w_found) begin
                    w_found     = 1'b1;
                    w_head_off  = IW'(i);
                    o_head_rd   = r_mem[w_slot[i]].rd;
                    o_head_data = r_mem[w_slot[i]].data;
                end
                o_pending[r_mem[w_slot[i]].rd] = 1'b1;
                if (r_mem[w_slot[i]].rd == i_lka_rd) begin
                    o_lka_hit  = 1'b1;
                    o_lka_data = r_mem[w_slot[i]].data;
                end
                if (r_mem[w_slot[i]].rd == i_lkb_rd) begin
                    o_lkb_hit  = 1'b1;
                    o_lkb_data = r_mem[w_slot[i]].data;
                end
            end
        end
        o_pending[0] = 1'b0;
    end

    // Retire the popped entry together with any dead slots in front of it;
    // when idle, still reclaim dead slots at the head so they free space.
    always_comb begin
        w_pop = i_pop && w_found;
        if (w_pop)
            w_adv = CW'(w_head_off) + CW'(1);
        else if (w_found)
            w_adv = CW'(w_head_off);
        else
            w_adv = r_count;
        w_rptr_sum = SW'(r_rptr) + SW'(w_adv);
        if (w_rptr_sum >= SW'(DEPTH))
            w_rptr_sum = w_rptr_sum - SW'(DEPTH);
        w_rptr_nxt = w_rptr_sum[IW-1:0];
        if (r_wptr == IW'(DEPTH - 1))
            w_wptr_nxt = '0;
        else
            w_wptr_nxt = r_wptr + IW'(1);
    end

    assign o_head_vld = w_found;
    assign o_full     = (r_count == CW'(DEPTH));

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_inv_en && r_mem[i].valid && (r_mem[i].rd == i_inv_rd))
                    r_mem[i].valid <= 1'b0;
            end
            if (i_push) begin
                r_mem[r_wptr] <= '{valid: 1'b1, rd: i_push_rd, data: i_push_data};
                r_wptr        <= w_wptr_nxt;
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= r_count - w_adv + CW'(i_push);
        end
    end

endmodule : rf_wb_fifo
`default_nettype wire

// File: rtl/rf_wb_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rf_wb_ctrl
// Brief   : Register-file writeback arbiter. ALU results write immediately;
//           load results queue in a small buffer and drain when the ALU is
//           idle. Read ports are bypassed from the write in flight and from
//           the buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module rf_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
)(
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               alu_valid,
    input  logic [ADDR_W-1:0]  alu_rd,
    input  logic [REG_W-1:0]   alu_data,
    input  logic               ld_valid,
    input  logic [ADDR_W-1:0]  ld_rd,
    input  logic [REG_W-1:0]   ld_data,
    output logic               ld_ready,
    output logic               WR,
    output logic [ADDR_W-1:0]  RW,
    output logic [REG_W-1:0]   DW,
    input  logic [ADDR_W-1:0]  RA,
    input  logic [ADDR_W-1:0]  RB,
    input  logic [REG_W-1:0]   DA_rf,
    input  logic [REG_W-1:0]   DB_rf,
    output logic [REG_W-1:0]   DA,
    output logic [REG_W-1:0]   DB,
    output logic [REG_W-1:0]   pending
);

    logic               r_wr;
    logic [ADDR_W-1:0]  r_rw;
    logic [REG_W-1:0]   r_dw;

    logic               w_full;
    logic               w_alu_req;
    logic               w_push;
    logic               w_pop;
    logic               w_head_vld;
    logic [ADDR_W-1:0]  w_head_rd;
    logic [REG_W-1:0]   w_head_data;
    logic               w_lka_hit;
    logic [REG_W-1:0]   w_lka_data;
    logic               w_lkb_hit;
    logic [REG_W-1:0]   w_lkb_data;

    // A load to r0 is accepted but discarded; a load colliding with a
    // same-cycle ALU write to the same register is older and thus dead.
    assign w_alu_req = alu_valid && (alu_rd != '0);
    assign ld_ready  = !w_full;
    assign w_push    = ld_valid && !w_full && (ld_rd != '0)
                       && !(w_alu_req && (alu_rd == ld_rd));
    assign w_pop     = !w_alu_req && w_head_vld;

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (HCLK),
        .rst         (HRESET),
        .i_push      (w_push),
        .i_push_rd   (ld_rd),
        .i_push_data (ld_data),
        .o_full      (w_full),
        .i_pop       (w_pop),
        .o_head_vld  (w_head_vld),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .i_inv_en    (w_alu_req),
        .i_inv_rd    (alu_rd),
        .i_lka_rd    (RA),
        .o_lka_hit   (w_lka_hit),
        .o_lka_data  (w_lka_data),
        .i_lkb_rd    (RB),
        .o_lkb_hit   (w_lkb_hit),
        .o_lkb_data  (w_lkb_data),
        .o_pending   (pending)
    );

    // Registered write port: ALU first, else oldest live load, else idle (hold address/data).
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wr <= 1'b0;
            r_rw <= '0;
            r_dw <= '0;
        end else if (w_alu_req) begin
            r_wr <= 1'b1;
            r_rw <= alu_rd;
            r_dw <= alu_data;
        end else if (w_pop) begin
            r_wr <= 1'b1;
            r_rw <= w_head_rd;
            r_dw <= w_head_data;
        end else begin
            r_wr <= 1'b0;
        end
    end

    assign WR = r_wr;
    assign RW = r_rw;
    assign DW = r_dw;

    assign DA = bypass(RA, r_wr, r_rw, r_dw, w_lka_hit, w_lka_data, DA_rf);
    assign DB = bypass(RB, r_wr, r_rw, r_dw, w_lkb_hit, w_lkb_data, DB_rf);

endmodule : rf_wb_ctrl
`default_nettype wire

// File: tb/tb_rf_wb_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_rf_wb_ctrl
// Brief   : Directed, table-driven bench for rf_wb_ctrl (DEPTH = 2) plus a
//           hand-written asynchronous-reset-while-draining sequence.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rf_wb_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        WR;
    logic [4:0]  RW;
    logic [31:0] DW;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic [31:0] DA_rf;
    logic [31:0] DB_rf;
    logic [31:0] DA;
    logic [31:0] DB;
    logic [31:0] pending;

    int n_total = 0;
    int n_bad   = 0;

    always #5 HCLK = ~HCLK;

    rf_wb_ctrl #(.DEPTH(2)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .WR        (WR),
        .RW        (RW),
        .DW        (DW),
        .RA        (RA),
        .RB        (RB),
        .DA_rf     (DA_rf),
        .DB_rf     (DB_rf),
        .DA        (DA),
        .DB        (DB),
        .pending   (pending)
    );

    // One cycle: inputs, pre-edge combinational expectations (DA/DB, ready),
    // then post-edge registered write port and pending bitmap.
    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ldd;
        logic [4:0]  ra;
        logic [31:0] rf;
        logic [31:0] e_da;
        logic        e_rdy;
        logic        e_wr;
        logic [4:0]  e_rw;
        logic [31:0] e_dw;
        logic [31:0] e_pend;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ar, input logic [31:0] ad,
        input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
        input logic [4:0] ra, input logic [31:0] rf, input logic [31:0] e_da,
        input logic e_rdy, input logic e_wr, input logic [4:0] e_rw,
        input logic [31:0] e_dw, input logic [31:0] e_pend);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ldd = ldd;
        v.ra = ra; v.rf = rf; v.e_da = e_da; v.e_rdy = e_rdy; v.e_wr = e_wr;
        v.e_rw = e_rw; v.e_dw = e_dw; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        //            av ar  ad            lv lr  ld      ra  rf            e_da          rdy wr rw  dw            pend
        // ALU write then read-back through the write bypass
        tbl[0]  = mk(1, 3,  32'hA5A5A5A5, 0, 0,  32'h0,  0,  32'h0,        32'h0,        1,  1, 3,  32'hA5A5A5A5, 32'h0);
        tbl[1]  = mk(0, 0,  32'h0,        0, 0,  32'h0,  3,  32'h0,        32'hA5A5A5A5, 1,  0, 3,  32'hA5A5A5A5, 32'h0);
        // two loads buffered behind a busy ALU, full, then drain r5, r6
        tbl[2]  = mk(1, 1,  32'h100,      1, 5,  32'h11, 5,  32'hDEAD,     32'hDEAD,     1,  1, 1,  32'h100,      32'h20);
        tbl[3]  = mk(1, 2,  32'h200,      1, 6,  32'h22, 5,  32'hDEAD,     32'h11,       1,  1, 2,  32'h200,      32'h60);
        tbl[4]  = mk(1, 4,  32'h400,      1, 8,  32'h88, 6,  32'h0,        32'h22,       0,  1, 4,  32'h400,      32'h60);
        tbl[5]  = mk(0, 0,  32'h0,        0, 0,  32'h0,  5,  32'hDEAD,     32'h11,       0,  1, 5,  32'h11,       32'h40);
        tbl[6]  = mk(0, 0,  32'h0,        0, 0,  32'h0,  5,  32'h55,       32'h11,       1,  1, 6,  32'h22,       32'h0);
        tbl[7]  = mk(0, 0,  32'h0,        0, 0,  32'h0,  6,  32'h0,        32'h22,       1,  0, 6,  32'h22,       32'h0);
        // buffered r7 killed by a younger ALU write; never written
        tbl[8]  = mk(1, 1,  32'h1,        1, 7,  32'h77, 7,  32'h0,        32'h0,        1,  1, 1,  32'h1,        32'h80);
        tbl[9]  = mk(1, 7,  32'h99,       0, 0,  32'h0,  7,  32'h0,        32'h77,       1,  1, 7,  32'h99,       32'h0);
        tbl[10] = mk(0, 0,  32'h0,        0, 0,  32'h0,  7,  32'h0,        32'h99,       1,  0, 7,  32'h99,       32'h0);
        tbl[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,  0,  32'h1234,     32'h0,        1,  0, 7,  32'h99,       32'h0);
        // r0 load and r0 ALU write both vanish
        tbl[12] = mk(1, 0,  32'hCD,       1, 0,  32'hAB, 0,  32'hFFFF,     32'h0,        1,  0, 7,  32'h99,       32'h0);
        tbl[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,  0,  32'hFFFF,     32'h0,        1,  0, 7,  32'h99,       32'h0);
        // same-cycle ALU and load to r10: load dropped
        tbl[14] = mk(1, 10, 32'hA0,       1, 10, 32'hB0, 0,  32'h0,        32'h0,        1,  1, 10, 32'hA0,       32'h0);
        tbl[15] = mk(0, 0,  32'h0,        0, 0,  32'h0,  10, 32'h0,        32'hA0,       1,  0, 10, 32'hA0,       32'h0);
        // head r11 invalidated; r12 pops with no bubble
        tbl[16] = mk(1, 1,  32'h5,        1, 11, 32'hB1, 0,  32'h0,        32'h0,        1,  1, 1,  32'h5,        32'h800);
        tbl[17] = mk(1, 2,  32'h6,        1, 12, 32'hC2, 11, 32'h0,        32'hB1,       1,  1, 2,  32'h6,        32'h1800);
        tbl[18] = mk(1, 11, 32'hEE,       0, 0,  32'h0,  12, 32'h0,        32'hC2,       0,  1, 11, 32'hEE,       32'h1000);
        tbl[19] = mk(0, 0,  32'h0,        0, 0,  32'h0,  11, 32'h1111,     32'hEE,       0,  1, 12, 32'hC2,       32'h0);
        tbl[20] = mk(0, 0,  32'h0,        0, 0,  32'h0,  12, 32'h0,        32'hC2,       1,  0, 12, 32'hC2,       32'h0);
        // two loads to r13: lookup returns the youngest, drain in order
        tbl[21] = mk(1, 1,  32'h5,        1, 13, 32'hD1, 0,  32'h0,        32'h0,        1,  1, 1,  32'h5,        32'h2000);
        tbl[22] = mk(1, 2,  32'h6,        1, 13, 32'hD2, 13, 32'h0,        32'hD1,       1,  1, 2,  32'h6,        32'h2000);
        tbl[23] = mk(1, 3,  32'h7,        0, 0,  32'h0,  13, 32'h0,        32'hD2,       0,  1, 3,  32'h7,        32'h2000);
        tbl[24] = mk(0, 0,  32'h0,        0, 0,  32'h0,  13, 32'h0,        32'hD2,       0,  1, 13, 32'hD1,       32'h2000);
        tbl[25] = mk(0, 0,  32'h0,        0, 0,  32'h0,  13, 32'h0,        32'hD1,       1,  1, 13, 32'hD2,       32'h0);
        tbl[26] = mk(0, 0,  32'h0,        0, 0,  32'h0,  0,  32'h0,        32'h0,        1,  0, 13, 32'hD2,       32'h0);

        HRESET    = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        RA = '0; RB = '0; DA_rf = '0; DB_rf = '0;

        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_wr",      {31'b0, WR},       32'h0);
        chk("rst_rw",      {27'b0, RW},       32'h0);
        chk("rst_dw",      DW,                32'h0);
        chk("rst_pending", pending,           32'h0);
        chk("rst_ready",   {31'b0, ld_ready}, 32'h1);
        HRESET = 1'b0;

        for (int i = 0; i < NV; i++) begin
            alu_valid = tbl[i].av;  alu_rd = tbl[i].ar;  alu_data = tbl[i].ad;
            ld_valid  = tbl[i].lv;  ld_rd  = tbl[i].lr;  ld_data  = tbl[i].ldd;
            RA = tbl[i].ra; DA_rf = tbl[i].rf;
            RB = tbl[i].ra; DB_rf = tbl[i].rf;
            #2;
            chk($sformatf("v%0d_da", i),  DA, tbl[i].e_da);
            chk($sformatf("v%0d_db", i),  DB, tbl[i].e_da);
            chk($sformatf("v%0d_rdy", i), {31'b0, ld_ready}, {31'b0, tbl[i].e_rdy});
            @(posedge HCLK);
            #1;
            chk($sformatf("v%0d_wr", i),   {31'b0, WR}, {31'b0, tbl[i].e_wr});
            chk($sformatf("v%0d_rw", i),   {27'b0, RW}, {27'b0, tbl[i].e_rw});
            chk($sformatf("v%0d_dw", i),   DW, tbl[i].e_dw);
            chk($sformatf("v%0d_pend", i), pending, tbl[i].e_pend);
        end

        // Buffer r9 behind a busy ALU, bypass it on port B, then reset mid-drain.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 32'h33;
        RA = '0; RB = '0; DA_rf = '0; DB_rf = '0;
        @(posedge HCLK);
        #1;
        ld_valid = 1'b0;
        alu_rd = 5'd2; alu_data = 32'h2;
        RB = 5'd9; DB_rf = 32'h0;
        #1;
        chk("r9_db_bypass", DB, 32'h33);
        chk("r9_pending",   pending, 32'h200);
        chk("r9_wr_alu",    {27'b0, RW}, 32'h1);
        @(posedge HCLK);
        #1;
        alu_valid = 1'b0;
        chk("r9_still_buf", pending, 32'h200);
        chk("pre_rst_wr",   {31'b0, WR}, 32'h1);
        DB_rf = 32'h5;
        #2;
        HRESET = 1'b1;
        #1;
        chk("arst_wr",      {31'b0, WR}, 32'h0);
        chk("arst_rw",      {27'b0, RW}, 32'h0);
        chk("arst_dw",      DW, 32'h0);
        chk("arst_pending", pending, 32'h0);
        chk("arst_ready",   {31'b0, ld_ready}, 32'h1);
        chk("arst_db",      DB, 32'h5);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge HCLK);
            #1;
            chk($sformatf("post_rst%0d_wr", k),   {31'b0, WR}, 32'h0);
            chk($sformatf("post_rst%0d_pend", k), pending, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_rf_wb_ctrl
`default_nettype wire
